// File: rtl/fma_pkg.sv
// Shared types and helpers for the iterative FMA multiply path.
// Used by the Booth encoder and the partial-product selector.
package fma_pkg;

    localparam logic ST_IDLE_ENC = 1'b0;
    localparam logic ST_RUN_ENC  = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE_ENC,
        S_RUN  = ST_RUN_ENC
    } enc_state_t;

    typedef struct packed {
        logic single;
        logic double;
        logic neg;
    } booth_digit_t;

    // Radix-4 digits needed to cover an unsigned operand, including the top zero-extension digit.
    function automatic int calc_ndig(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_serial_enc_if.sv
// Operand-in / Booth-digit-out handshake bundle of the serial Booth encoder.
interface booth_serial_enc_if
    import fma_pkg::*;
#(
    parameter int WIDTH = 11
);
    localparam int NDIG = calc_ndig(WIDTH);
    localparam int IW   = $clog2(NDIG);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_mult;
    logic             out_valid;
    logic             out_ready;
    logic             single;
    logic             double;
    logic             neg;
    logic [IW-1:0]    digit_idx;
    logic             last;

    modport master (
        output in_valid, in_mult, out_ready,
        input  in_ready, out_valid, single, double, neg, digit_idx, last
    );

    modport slave (
        input  in_valid, in_mult, out_ready,
        output in_ready, out_valid, single, double, neg, digit_idx, last
    );

endinterface

// File: rtl/booth_digit_enc.sv
// Combinational radix-4 Booth recoder: (y2i+1, y2i, y2i-1) -> {single, double, neg}.
module booth_digit_enc
    import fma_pkg::*;
(
    input  logic [2:0]   triplet,
    output booth_digit_t digit
);

    // Both zero codes map to 000 so a negative zero never reaches the selector.
    always_comb begin
        digit = '0;
        case (triplet)
            3'b001, 3'b010: digit.single = 1'b1;
            3'b011:         digit.double = 1'b1;
            3'b100:         begin digit.double = 1'b1; digit.neg = 1'b1; end
            3'b101, 3'b110: begin digit.single = 1'b1; digit.neg = 1'b1; end
            default:        digit = '0;
        endcase
    end

endmodule

// File: rtl/booth_serial_enc.sv
// Serial radix-4 modified-Booth encoder: one unsigned operand in, NDIG Booth digits out LSD first.
module booth_serial_enc
    import fma_pkg::*;
#(
    parameter int WIDTH = 11
)(
    input  logic               clk,
    input  logic               rst_n,
    booth_serial_enc_if.slave  bus
);

    localparam int NDIG = calc_ndig(WIDTH);
    localparam int IW   = $clog2(NDIG);
    localparam int SRW  = 2 * NDIG + 1;
    localparam int PAD  = 2 * NDIG - WIDTH;
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

    enc_state_t   state, state_nxt;
    logic [SRW-1:0] sr, sr_nxt;
    logic [IW-1:0]  idx, idx_nxt;
    logic           out_fire;
    logic           is_last;
    logic           accept;
    booth_digit_t   dig;

    assign bus.out_valid = (state == S_RUN);
    assign is_last       = bus.out_valid && (idx == LAST_IDX);
    assign out_fire      = bus.out_valid && bus.out_ready;
    // Back-to-back: a new operand may load on the same edge the last digit is consumed.
    assign bus.in_ready  = (state == S_IDLE) || (out_fire && is_last);
    assign accept        = bus.in_valid && bus.in_ready;

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        idx_nxt   = idx;
        if (out_fire) begin
            sr_nxt  = sr >> 2;
            idx_nxt = idx + 1'b1;
            if (is_last) begin
                idx_nxt   = '0;
                state_nxt = S_IDLE;
            end
        end
        if (accept) begin
            sr_nxt    = {{PAD{1'b0}}, bus.in_mult, 1'b0};
            idx_nxt   = '0;
            state_nxt = S_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            sr    <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            sr    <= sr_nxt;
            idx   <= idx_nxt;
        end
    end

    booth_digit_enc u_digit_enc (
        .triplet (sr[2:0]),
        .digit   (dig)
    );

    assign bus.single    = bus.out_valid & dig.single;
    assign bus.double    = bus.out_valid & dig.double;
    assign bus.neg       = bus.out_valid & dig.neg;
    assign bus.last      = is_last;
    assign bus.digit_idx = idx;

endmodule

// File: tb/tb_booth_serial_enc.sv
// Directed and randomized checks of the serial Booth encoder at WIDTH=11.
module tb_booth_serial_enc;

    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    booth_serial_enc_if #(.WIDTH(11)) bus ();

    booth_serial_enc #(.WIDTH(11)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {out_valid, digit_idx, single, double, neg, last}
    function automatic logic [7:0] obs_st();
        return {bus.out_valid, bus.digit_idx, bus.single, bus.double, bus.neg, bus.last};
    endfunction

    // digs packs the six expected {s,d,n} triples, digit i at [3*i +: 3]
    function automatic logic [7:0] exp_st(input int i, input logic [17:0] digs);
        return {1'b1, 3'(i), digs[3*i +: 3], (i == 5)};
    endfunction

    task automatic run_op(input string name, input logic [10:0] m, input logic [17:0] digs);
        bus.in_valid  = 1'b1;
        bus.in_mult   = m;
        bus.out_ready = 1'b1;
        #1;
        check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_mult  = ~m;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("%s_d%0d", name, i), 32'(obs_st()), 32'(exp_st(i, digs)));
            tick();
        end
        #1;
        check({name, "_idle"}, 32'({obs_st(), bus.in_ready}), 32'h001);
        tick();
    endtask

    localparam logic [17:0] DIGS_ZERO = 18'b000_000_000_000_000_000;
    localparam logic [17:0] DIGS_7FF  = 18'b010_000_000_000_000_101;
    localparam logic [17:0] DIGS_555  = 18'b100_100_100_100_100_100;
    localparam logic [17:0] DIGS_400  = 18'b100_000_000_000_000_000;
    localparam logic [17:0] DIGS_001  = 18'b000_000_000_000_000_100;

    initial begin
        int sum, got, bad, cyc, mag;
        logic [10:0] m;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mult   = '0;
        bus.out_ready = 1'b0;
        #12;
        check("reset_st", 32'({obs_st(), bus.in_ready}), 32'h001);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_op("zero", 11'h000, DIGS_ZERO);
        run_op("ones", 11'h7FF, DIGS_7FF);
        run_op("alt",  11'h555, DIGS_555);
        run_op("msb",  11'h400, DIGS_400);

        // Backpressure at idx 2, then back-to-back operand on the last handshake
        bus.in_valid  = 1'b1;
        bus.in_mult   = 11'h555;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("bp_d%0d", i), 32'(obs_st()), 32'(exp_st(i, DIGS_555)));
            tick();
        end
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_hold%0d", k), 32'(obs_st()), 32'(exp_st(2, DIGS_555)));
            check($sformatf("bp_in_ready%0d", k), 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        for (int i = 2; i < 5; i++) begin
            #1;
            check($sformatf("bp_d%0d", i), 32'(obs_st()), 32'(exp_st(i, DIGS_555)));
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_mult  = 11'h7FF;
        #1;
        check("bp_d5", 32'(obs_st()), 32'(exp_st(5, DIGS_555)));
        check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_mult  = 11'h000;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("b2b_d%0d", i), 32'(obs_st()), 32'(exp_st(i, DIGS_7FF)));
            tick();
        end
        #1;
        check("b2b_idle", 32'({obs_st(), bus.in_ready}), 32'h001);
        tick();

        // Reset in the middle of an operand
        bus.in_valid = 1'b1;
        bus.in_mult  = 11'h7FF;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        #1;
        check("rst_pre_d3", 32'(obs_st()), 32'(exp_st(3, DIGS_7FF)));
        rst_n = 1'b0;
        #1;
        check("rst_during", 32'({obs_st(), bus.in_ready}), 32'h001);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_after", 32'({obs_st(), bus.in_ready}), 32'h001);
        run_op("post_rst", 11'h001, DIGS_001);

        // Random operands with random downstream stalls; reconstruct the value from digits
        for (int op = 0; op < 1000; op++) begin
            m             = 11'($urandom);
            bus.in_valid  = 1'b1;
            bus.in_mult   = m;
            bus.out_ready = 1'b0;
            tick();
            bus.in_valid = 1'b0;
            bus.in_mult  = 11'($urandom);
            sum = 0; got = 0; bad = 0; cyc = 0;
            while (got < 6 && cyc < 200) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                #1;
                if (bus.out_valid && bus.out_ready) begin
                    if (int'(bus.digit_idx) != got) bad++;
                    if (bus.single && bus.double) bad++;
                    if (bus.neg && !bus.single && !bus.double) bad++;
                    if (bus.last != (got == 5)) bad++;
                    mag = bus.single ? 1 : (bus.double ? 2 : 0);
                    sum += (bus.neg ? -mag : mag) * (1 << (2 * got));
                    got++;
                end
                tick();
                cyc++;
            end
            bus.out_ready = 1'b0;
            check($sformatf("rnd%0d_cnt", op), 32'(got), 32'd6);
            check($sformatf("rnd%0d_flags", op), 32'(bad), 32'd0);
            check($sformatf("rnd%0d_sum", op), 32'(sum), 32'(m));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
